// File: rtl/alu_sequencer.sv
// Multi-cycle ALU execute/writeback controller in front of a single-read-port register file.
// Optional ALU_SEQ_SAME_SRC_EN: skip the second read when both sources name the same register.
module alu_sequencer #(
  parameter int DW = 16,
  parameter int AW = 4
) (
  input  logic          clk,
  input  logic          clear,
  input  logic          instr_valid,
  output logic          instr_ready,
  input  logic [2:0]    opcode,
  input  logic [AW-1:0] dst,
  input  logic [AW-1:0] src_a,
  input  logic [AW-1:0] src_b,
  output logic          rd_en,
  output logic [AW-1:0] rd_addr,
  input  logic [DW-1:0] rd_data,
  output logic          wr_en,
  output logic [AW-1:0] wr_addr,
  output logic [DW-1:0] wr_data,
  output logic [DW-1:0] result,
  output logic          zero,
  output logic          ovf,
  output logic          done,
  output logic [2:0]    state_dbg
);

  typedef enum logic [2:0] {IDLE, RD_A, RD_B, EXEC, WB} state_t;

  state_t        state;
  logic [2:0]    op_q;
  logic [AW-1:0] dst_q;
  logic [AW-1:0] src_a_q;
  logic [AW-1:0] src_b_q;
  logic [DW-1:0] op_a;
  logic [DW-1:0] op_b;
  logic [DW-1:0] alu_res;
  logic          alu_ovf;

  // Handshake: an instruction is taken on a rising edge where instr_valid and
  // instr_ready are both high; ready is only high in IDLE and never while clear is low.
  assign instr_ready = clear && (state == IDLE);
  assign state_dbg   = state;

  always_comb begin
    alu_res = '0;
    alu_ovf = 1'b0;
    case (op_q)
      3'b000: begin
        alu_res = op_a + op_b;
        alu_ovf = (op_a[DW-1] == op_b[DW-1]) && (alu_res[DW-1] != op_a[DW-1]);
      end
      3'b001: begin
        alu_res = op_a - op_b;
        alu_ovf = (op_a[DW-1] != op_b[DW-1]) && (alu_res[DW-1] != op_a[DW-1]);
      end
      3'b010: alu_res = op_a & op_b;
      3'b011: alu_res = op_a | op_b;
      3'b100: alu_res = op_a ^ op_b;
      3'b101: alu_res = op_a << op_b[3:0];
      3'b110: alu_res = op_a >> op_b[3:0];
      default: alu_res = op_a;
    endcase
  end

  always_ff @(posedge clk or negedge clear) begin
    if (!clear) begin
      state   <= IDLE;
      op_q    <= '0;
      dst_q   <= '0;
      src_a_q <= '0;
      src_b_q <= '0;
      op_a    <= '0;
      op_b    <= '0;
      rd_en   <= 1'b0;
      rd_addr <= '0;
      wr_en   <= 1'b0;
      wr_addr <= '0;
      wr_data <= '0;
      result  <= '0;
      zero    <= 1'b1;
      ovf     <= 1'b0;
      done    <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (instr_valid) begin
            op_q    <= opcode;
            dst_q   <= dst;
            src_a_q <= src_a;
            src_b_q <= src_b;
            rd_en   <= 1'b1;
            rd_addr <= src_a;
            state   <= RD_A;
          end
        end
        RD_A: begin
          op_a <= rd_data;
`ifdef ALU_SEQ_SAME_SRC_EN
          if (src_a_q == src_b_q) begin
            op_b  <= rd_data;
            rd_en <= 1'b0;
            state <= EXEC;
          end else begin
            rd_addr <= src_b_q;
            state   <= RD_B;
          end
`else
          rd_addr <= src_b_q;
          state   <= RD_B;
`endif
        end
        RD_B: begin
          op_b  <= rd_data;
          rd_en <= 1'b0;
          state <= EXEC;
        end
        EXEC: begin
          result  <= alu_res;
          zero    <= (alu_res == '0);
          ovf     <= alu_ovf;
          wr_en   <= 1'b1;
          wr_addr <= dst_q;
          wr_data <= alu_res;
          state   <= WB;
        end
        WB: begin
          wr_en <= 1'b0;
          done  <= 1'b1;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
